// File: rtl/alu_pwr_seq.sv
// ALU power-domain sequencer: drain -> isolate -> power off, power on -> reset release -> de-isolate.
// All outputs registered; sleep/wake requests against the current direction are held as pending flags.
module alu_pwr_seq #(
   parameter int ISO_CYCLES    = 2,
   parameter int PWRUP_CYCLES  = 8,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sleep_req,
   input  logic        wake_req,
   input  logic        alu_busy,
   input  logic [15:0] clamp_cfg,
   input  logic        clamp_cfg_we,
   output logic        alu_pwr_en,
   output logic        iso_en,
   output logic        alu_rst_n,
   output logic [15:0] clamp_value,
   output logic [2:0]  pwr_state,
   output logic        sleep_ack,
   output logic        wake_ack,
   output logic        drain_to
);

   localparam int CNT_MAX_A = (ISO_CYCLES > PWRUP_CYCLES) ? ISO_CYCLES : PWRUP_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > DRAIN_TIMEOUT) ? CNT_MAX_A : DRAIN_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX) + 1;

   typedef enum logic [2:0] {
      S_ON      = 3'd0,
      S_DRAIN   = 3'd1,
      S_ISO     = 3'd2,
      S_OFF     = 3'd3,
      S_PWRUP   = 3'd4,
      S_RST_REL = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sleep_pend_q, sleep_pend_d;
   logic               wake_pend_q, wake_pend_d;
   logic               sleep_ack_q, sleep_ack_d;
   logic               wake_ack_q, wake_ack_d;
   logic               drain_to_q, drain_to_d;
   logic [15:0]        clamp_q, clamp_d;
   logic               pwr_en_q, pwr_en_d;
   logic               iso_q, iso_d;
   logic               rst_n_q, rst_n_d;

   // {pwr_en, iso_en, rst_n} for each state; illegal codes decode as OFF
   function automatic logic [2:0] decode(input state_e s);
      case (s)
         S_ON:      decode = 3'b101;
         S_DRAIN:   decode = 3'b101;
         S_ISO:     decode = 3'b111;
         S_OFF:     decode = 3'b010;
         S_PWRUP:   decode = 3'b110;
         S_RST_REL: decode = 3'b111;
         default:   decode = 3'b010;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      sleep_pend_d = sleep_pend_q;
      wake_pend_d  = wake_pend_q;
      sleep_ack_d  = 1'b0;
      wake_ack_d   = 1'b0;
      drain_to_d   = drain_to_q;
      clamp_d      = (clamp_cfg_we && !iso_q) ? clamp_cfg : clamp_q;

      case (state_q)
         S_ON: begin
            if (sleep_req || sleep_pend_q) begin
               state_d      = S_DRAIN;
               sleep_pend_d = 1'b0;
            end
         end
         S_DRAIN: begin
            if (wake_req) wake_pend_d = 1'b1;
            if (!alu_busy) begin
               state_d = S_ISO;
            end else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
               state_d    = S_ISO;
               drain_to_d = 1'b1;
            end
         end
         S_ISO: begin
            if (wake_req) wake_pend_d = 1'b1;
            if (cnt_q == CNT_W'(ISO_CYCLES - 1)) begin
               state_d     = S_OFF;
               sleep_ack_d = 1'b1;
            end
         end
         S_OFF: begin
            if (wake_req || wake_pend_q) begin
               state_d     = S_PWRUP;
               wake_pend_d = 1'b0;
            end
         end
         S_PWRUP: begin
            if (sleep_req) sleep_pend_d = 1'b1;
            if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) state_d = S_RST_REL;
         end
         S_RST_REL: begin
            if (sleep_req) sleep_pend_d = 1'b1;
            if (cnt_q == CNT_W'(ISO_CYCLES - 1)) begin
               state_d    = S_ON;
               wake_ack_d = 1'b1;
               drain_to_d = 1'b0;
            end
         end
         default: state_d = S_OFF;
      endcase

      // Dwell counter restarts on every state change and idles in the resting states
      if (state_d != state_q || state_q == S_ON || state_q == S_OFF)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CNT_W'(1);

      {pwr_en_d, iso_d, rst_n_d} = decode(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_ON;
         cnt_q        <= '0;
         sleep_pend_q <= 1'b0;
         wake_pend_q  <= 1'b0;
         sleep_ack_q  <= 1'b0;
         wake_ack_q   <= 1'b0;
         drain_to_q   <= 1'b0;
         clamp_q      <= 16'h0000;
         pwr_en_q     <= 1'b1;
         iso_q        <= 1'b0;
         rst_n_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sleep_pend_q <= sleep_pend_d;
         wake_pend_q  <= wake_pend_d;
         sleep_ack_q  <= sleep_ack_d;
         wake_ack_q   <= wake_ack_d;
         drain_to_q   <= drain_to_d;
         clamp_q      <= clamp_d;
         pwr_en_q     <= pwr_en_d;
         iso_q        <= iso_d;
         rst_n_q      <= rst_n_d;
      end
   end

   assign alu_pwr_en  = pwr_en_q;
   assign iso_en      = iso_q;
   assign alu_rst_n   = rst_n_q;
   assign clamp_value = clamp_q;
   assign pwr_state   = state_q;
   assign sleep_ack   = sleep_ack_q;
   assign wake_ack    = wake_ack_q;
   assign drain_to    = drain_to_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Scoreboard bench for alu_pwr_seq: stimulus pushes expected output snapshots tagged with a cycle number,
// a negedge monitor pops and compares them.
module tb_alu_pwr_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sleep_req = 1'b0;
   logic        wake_req = 1'b0;
   logic        alu_busy = 1'b0;
   logic [15:0] clamp_cfg = 16'h0000;
   logic        clamp_cfg_we = 1'b0;
   logic        alu_pwr_en, iso_en, alu_rst_n;
   logic [15:0] clamp_value;
   logic [2:0]  pwr_state;
   logic        sleep_ack, wake_ack, drain_to;

   alu_pwr_seq dut (
      .clk          (clk),
      .rst          (rst),
      .sleep_req    (sleep_req),
      .wake_req     (wake_req),
      .alu_busy     (alu_busy),
      .clamp_cfg    (clamp_cfg),
      .clamp_cfg_we (clamp_cfg_we),
      .alu_pwr_en   (alu_pwr_en),
      .iso_en       (iso_en),
      .alu_rst_n    (alu_rst_n),
      .clamp_value  (clamp_value),
      .pwr_state    (pwr_state),
      .sleep_ack    (sleep_ack),
      .wake_ack     (wake_ack),
      .drain_to     (drain_to)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          q_cyc[$];
   logic [24:0] q_exp[$];
   string       q_tag[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] m_clamp = 16'h0000;
   logic        m_dto = 1'b0;
   logic [24:0] mon_act;

   // Power-state table: {pwr_en, iso_en, rst_n}
   function automatic logic [2:0] dec(input logic [2:0] st);
      case (st)
         3'd0: dec = 3'b101;
         3'd1: dec = 3'b101;
         3'd2: dec = 3'b111;
         3'd3: dec = 3'b010;
         3'd4: dec = 3'b110;
         3'd5: dec = 3'b111;
         default: dec = 3'b010;
      endcase
   endfunction

   task automatic expect_at(input int at, input string tag, input logic [2:0] st,
                            input logic sack, input logic wack);
      q_cyc.push_back(at);
      q_exp.push_back({st, dec(st), sack, wack, m_dto, m_clamp});
      q_tag.push_back(tag);
   endtask

   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         mon_act = {pwr_state, alu_pwr_en, iso_en, alu_rst_n, sleep_ack, wake_ack, drain_to, clamp_value};
         n_cmp++;
         if (q_cyc[0] != cyc || mon_act !== q_exp[0]) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got st=%0d pwr/iso/rstn=%b sack=%b wack=%b dto=%b clamp=%h ; want(cyc %0d) st=%0d pwr/iso/rstn=%b sack=%b wack=%b dto=%b clamp=%h",
                     q_tag[0], cyc, mon_act[24:22], mon_act[21:19], mon_act[18], mon_act[17], mon_act[16], mon_act[15:0],
                     q_cyc[0], q_exp[0][24:22], q_exp[0][21:19], q_exp[0][18], q_exp[0][17], q_exp[0][16], q_exp[0][15:0]);
         end
         void'(q_cyc.pop_front());
         void'(q_exp.pop_front());
         void'(q_tag.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_sleep();
      sleep_req = 1'b1;
      tick(1);
      sleep_req = 1'b0;
   endtask

   task automatic pulse_wake();
      wake_req = 1'b1;
      tick(1);
      wake_req = 1'b0;
   endtask

   // Minimum-latency sleep from ON with alu_busy low
   task automatic sleep_seq(input string tag);
      int c;
      c = cyc;
      expect_at(c + 1, {tag, "_drain"}, 3'd1, 1'b0, 1'b0);
      expect_at(c + 2, {tag, "_iso"},   3'd2, 1'b0, 1'b0);
      expect_at(c + 3, {tag, "_iso"},   3'd2, 1'b0, 1'b0);
      expect_at(c + 4, {tag, "_off_ack"}, 3'd3, 1'b1, 1'b0);
      expect_at(c + 5, {tag, "_off"},   3'd3, 1'b0, 1'b0);
      pulse_sleep();
      tick(5);
   endtask

   // Wake from OFF; drain_to is expected to clear together with wake_ack
   task automatic wake_seq(input string tag);
      int c;
      c = cyc;
      for (int k = 1; k <= 8; k++) expect_at(c + k, {tag, "_pwrup"}, 3'd4, 1'b0, 1'b0);
      expect_at(c + 9,  {tag, "_rst_rel"}, 3'd5, 1'b0, 1'b0);
      expect_at(c + 10, {tag, "_rst_rel"}, 3'd5, 1'b0, 1'b0);
      m_dto = 1'b0;
      expect_at(c + 11, {tag, "_on_ack"}, 3'd0, 1'b0, 1'b1);
      expect_at(c + 12, {tag, "_on"},     3'd0, 1'b0, 1'b0);
      pulse_wake();
      tick(11);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      tick(2);
      expect_at(cyc, "reset_state", 3'd0, 1'b0, 1'b0);
      tick(1);
      rst = 1'b0;
      expect_at(cyc, "reset_release", 3'd0, 1'b0, 1'b0);
      tick(2);

      sleep_seq("t1");
      wake_seq("t2");

      // Busy for the first 10 DRAIN cycles
      alu_busy = 1'b1;
      c = cyc;
      for (int k = 1; k <= 10; k++) expect_at(c + k, "t3a_drain", 3'd1, 1'b0, 1'b0);
      expect_at(c + 11, "t3a_iso", 3'd2, 1'b0, 1'b0);
      expect_at(c + 12, "t3a_iso", 3'd2, 1'b0, 1'b0);
      expect_at(c + 13, "t3a_off_ack", 3'd3, 1'b1, 1'b0);
      expect_at(c + 14, "t3a_off", 3'd3, 1'b0, 1'b0);
      pulse_sleep();
      tick(9);
      alu_busy = 1'b0;
      tick(5);
      wake_seq("t3a_wake");

      // Busy stuck high: forced isolation after 64 DRAIN cycles
      alu_busy = 1'b1;
      c = cyc;
      for (int k = 1; k <= 64; k++) expect_at(c + k, "t3b_drain", 3'd1, 1'b0, 1'b0);
      m_dto = 1'b1;
      expect_at(c + 65, "t3b_iso_to", 3'd2, 1'b0, 1'b0);
      expect_at(c + 66, "t3b_iso_to", 3'd2, 1'b0, 1'b0);
      expect_at(c + 67, "t3b_off_ack", 3'd3, 1'b1, 1'b0);
      expect_at(c + 68, "t3b_off", 3'd3, 1'b0, 1'b0);
      pulse_sleep();
      tick(67);
      alu_busy = 1'b0;
      wake_seq("t3b_wake");

      // Opposite-direction requests become pending
      c = cyc;
      expect_at(c + 1, "t4_drain", 3'd1, 1'b0, 1'b0);
      expect_at(c + 2, "t4_iso", 3'd2, 1'b0, 1'b0);
      expect_at(c + 3, "t4_iso", 3'd2, 1'b0, 1'b0);
      expect_at(c + 4, "t4_off_ack", 3'd3, 1'b1, 1'b0);
      for (int k = 5; k <= 12; k++) expect_at(c + k, "t4_pwrup", 3'd4, 1'b0, 1'b0);
      expect_at(c + 13, "t4_rst_rel", 3'd5, 1'b0, 1'b0);
      expect_at(c + 14, "t4_rst_rel", 3'd5, 1'b0, 1'b0);
      expect_at(c + 15, "t4_on_ack", 3'd0, 1'b0, 1'b1);
      expect_at(c + 16, "t4_pend_drain", 3'd1, 1'b0, 1'b0);
      expect_at(c + 17, "t4_iso2", 3'd2, 1'b0, 1'b0);
      expect_at(c + 18, "t4_iso2", 3'd2, 1'b0, 1'b0);
      expect_at(c + 19, "t4_off2_ack", 3'd3, 1'b1, 1'b0);
      expect_at(c + 20, "t4_off2", 3'd3, 1'b0, 1'b0);
      pulse_sleep();
      tick(1);
      pulse_wake();
      tick(3);
      pulse_sleep();
      tick(14);

      // Simultaneous requests in OFF: wake wins, sleep not remembered
      c = cyc;
      for (int k = 1; k <= 8; k++) expect_at(c + k, "t4b_pwrup", 3'd4, 1'b0, 1'b0);
      expect_at(c + 9,  "t4b_rst_rel", 3'd5, 1'b0, 1'b0);
      expect_at(c + 10, "t4b_rst_rel", 3'd5, 1'b0, 1'b0);
      expect_at(c + 11, "t4b_on_ack", 3'd0, 1'b0, 1'b1);
      expect_at(c + 12, "t4b_on_stay", 3'd0, 1'b0, 1'b0);
      expect_at(c + 13, "t4b_on_stay", 3'd0, 1'b0, 1'b0);
      sleep_req = 1'b1;
      wake_req  = 1'b1;
      tick(1);
      sleep_req = 1'b0;
      wake_req  = 1'b0;
      tick(12);

      // Clamp write accepted while de-isolated, dropped while isolated
      c = cyc;
      clamp_cfg    = 16'hDEAD;
      clamp_cfg_we = 1'b1;
      m_clamp      = 16'hDEAD;
      expect_at(c + 1, "t5_clamp_wr", 3'd0, 1'b0, 1'b0);
      tick(1);
      clamp_cfg_we = 1'b0;
      tick(1);
      sleep_seq("t5");
      clamp_cfg    = 16'hBEEF;
      clamp_cfg_we = 1'b1;
      tick(1);
      clamp_cfg_we = 1'b0;
      expect_at(cyc, "t5_clamp_drop", 3'd3, 1'b0, 1'b0);
      tick(1);
      expect_at(cyc, "t5_clamp_drop2", 3'd3, 1'b0, 1'b0);
      tick(1);

      // Asynchronous reset in the middle of PWRUP
      c = cyc;
      expect_at(c + 1, "t6_pwrup", 3'd4, 1'b0, 1'b0);
      expect_at(c + 2, "t6_pwrup", 3'd4, 1'b0, 1'b0);
      pulse_wake();
      tick(2);
      #1;
      rst     = 1'b1;
      m_clamp = 16'h0000;
      m_dto   = 1'b0;
      expect_at(cyc, "t6_async_rst", 3'd0, 1'b0, 1'b0);
      tick(1);
      expect_at(cyc, "t6_rst_held", 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(1);
      expect_at(cyc, "t6_after_rst", 3'd0, 1'b0, 1'b0);
      tick(1);
      expect_at(cyc, "t6_after_rst", 3'd0, 1'b0, 1'b0);
      tick(2);

      if (q_cyc.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", q_cyc.size());
         n_err += q_cyc.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
Power sequencer for the ALU power domain. It sits directly upstream of the ALU wrapper and drives that wrapper's alu_pwr_en, iso_en, domain reset and clamp value. It turns single-cycle sleep/wake requests into an ordered, timed sequence: drain → isolate → power off, and power on → reset release → de-isolate. The programmable clamp value is held here and feeds the wrapper's isolation clamp.

Parameters:
ISO_CYCLES, 2, cycles isolation is held before power-off and after reset release (min 1)
PWRUP_CYCLES, 8, cycles power is on with domain reset held, before reset release (min 1)
DRAIN_TIMEOUT, 64, max cycles to wait for alu_busy to drop before forcing isolation (min 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sleep_req  input  1  single-cycle pulse; request to power down the ALU domain
wake_req  input  1  single-cycle pulse; request to power up the ALU domain
alu_busy  input  1  ALU has an operation in flight
clamp_cfg  input  16  new clamp value
clamp_cfg_we  input  1  write strobe for clamp_cfg
alu_pwr_en  output  1  1 = ALU domain powered
iso_en  output  1  1 = ALU outputs isolated (clamped)
alu_rst_n  output  1  active-low ALU domain reset
clamp_value  output  16  clamp value to the wrapper
pwr_state  output  3  current FSM state code
sleep_ack  output  1  1-cycle pulse on entry to OFF
wake_ack  output  1  1-cycle pulse on entry to ON from RST_REL
drain_to  output  1  sticky flag: last sleep forced isolation on timeout

Behaviour:
- States and codes: ON=0, DRAIN=1, ISO=2, OFF=3, PWRUP=4, RST_REL=5. Codes 6 and 7 go to OFF.
- Outputs are a Moore decode of the registered state, except the ack pulses and drain_to, which are registered. Decode (pwr_en/iso_en/alu_rst_n):
  - ON 1/0/1
  - DRAIN 1/0/1
  - ISO 1/1/1
  - OFF 0/1/0
  - PWRUP 1/1/0
  - RST_REL 1/1/1
- Reset (async, rst=1): state=ON, clamp_value=16'h0000, sleep_ack=0, wake_ack=0, drain_to=0, internal counter=0, pending flags=0. The outputs therefore read alu_pwr_en=1, iso_en=0, alu_rst_n=1, pwr_state=0.
- ON: sleep_req (or a pending sleep) → DRAIN on the next edge. wake_req in ON is ignored.
- DRAIN: the counter counts cycles.
  - alu_busy=0 → ISO next edge.
  - If the counter reaches DRAIN_TIMEOUT with alu_busy still 1 → ISO and set drain_to.
- ISO: held for exactly ISO_CYCLES cycles, then OFF.
- OFF: on entry, sleep_ack=1 for one cycle. wake_req (or a pending wake) → PWRUP next edge. sleep_req in OFF is ignored.
- PWRUP: held PWRUP_CYCLES cycles, then RST_REL.
- RST_REL: held ISO_CYCLES cycles, then ON. On entry to ON, wake_ack=1 for one cycle and drain_to clears.
- Minimum sleep latency (alu_busy=0, defaults): sleep_req sampled at edge 0 → DRAIN at 1, ISO at 2–3, OFF at 4 with sleep_ack=1.
- Minimum wake latency: wake_req sampled at edge 0 → PWRUP at 1–8, RST_REL at 9–10, ON at 11 with wake_ack=1.
- Requests against the current direction:
  - wake_req during DRAIN/ISO sets wake_pend. On reaching OFF, the FSM goes to PWRUP next edge. sleep_ack still pulses.
  - sleep_req during PWRUP/RST_REL sets sleep_pend. On reaching ON, the FSM goes to DRAIN next edge. wake_ack still pulses.
  - A pending flag clears when consumed.
- Same-direction repeats: sleep_req during DRAIN/ISO and wake_req during PWRUP/RST_REL are ignored.
- Simultaneous sleep_req and wake_req in the same cycle: in ON, sleep wins. In OFF, wake wins. In transit states, only the opposite-direction pending flag is set.
- Clamp write: clamp_cfg_we=1 with iso_en=0 → clamp_value=clamp_cfg next edge. Writes while iso_en=1 are dropped.
- Async rst mid-sequence returns immediately to ON decode. No ack is issued.

Test Plan:
1. Reset, then sleep_req pulse with alu_busy=0 → pwr_state 1,2,2,3 at edges 1–4; iso_en=1 from edge 2; alu_pwr_en=0 and sleep_ack=1 at edge 4.
2. From OFF, wake_req → alu_rst_n=0 and pwr_en=1 for 8 cycles, then rst_n=1 with iso=1 for 2 cycles; ON with iso_en=0 and wake_ack=1 at edge 11.
3. sleep_req with alu_busy=1 for 10 cycles → DRAIN lasts 10 cycles, then ISO, drain_to=0. Repeat with busy stuck high → ISO after 64 cycles, drain_to=1, cleared on next wake_ack.
4. wake_req issued in ISO → sleep_ack pulses at OFF, PWRUP entered the next cycle. sleep_req issued in PWRUP → DRAIN entered the cycle after ON.
5. Write clamp_cfg=16'hDEAD in ON → clamp_value=16'hDEAD. Write 16'hBEEF during OFF → clamp_value stays 16'hDEAD.
6. rst asserted mid-PWRUP → immediately pwr_state=0, iso_en=0, alu_pwr_en=1, alu_rst_n=1, clamp_value=0, no acks.
